mult_arbiter: RTL

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// Two-requester arbiter in front of a shared signed 4x4 multiplier.
// Grants alternate on contention; one operation is in flight at a time.
module mult_arbiter #(
    parameter int CALC_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       req1_ready,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_p,
    input  logic       rsp_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(CALC_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_prio;
    logic [2:0]        r_cnt;
    logic [3:0]        r_a;
    logic [3:0]        r_b;
    logic              r_id;
    logic              r_rsp_valid;
    logic              r_rsp_id;
    logic [7:0]        r_rsp_p;
    logic              w_gnt0;
    logic              w_gnt1;
    logic signed [7:0] w_a_ext;
    logic signed [7:0] w_b_ext;
    logic signed [7:0] w_prod;

    // Sign-extend before multiplying so the 8-bit product is exact.
    assign w_a_ext = $signed({{4{r_a[3]}}, r_a});
    assign w_b_ext = $signed({{4{r_b[3]}}, r_b});
    assign w_prod  = w_a_ext * w_b_ext;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant decode and next-state logic; grants are gated by rst.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!rst && req0_valid && (!req1_valid || (r_prio == 1'b0))) begin
                    w_gnt0 = 1'b1;
                end else if (!rst && req1_valid && (!req0_valid || (r_prio == 1'b1))) begin
                    w_gnt1 = 1'b1;
                end else begin
                    w_gnt0 = 1'b0;
                    w_gnt1 = 1'b0;
                end
                if (w_gnt0 || w_gnt1) begin
                    w_state_nxt = ST_CALC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand capture, countdown, priority pointer and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio      <= 1'b0;
            r_cnt       <= 3'd0;
            r_a         <= 4'd0;
            r_b         <= 4'd0;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_p     <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt0) begin
                        r_a    <= req0_a;
                        r_b    <= req0_b;
                        r_id   <= 1'b0;
                        r_prio <= 1'b1;
                        r_cnt  <= CNT_LOAD;
                    end else if (w_gnt1) begin
                        r_a    <= req1_a;
                        r_b    <= req1_b;
                        r_id   <= 1'b1;
                        r_prio <= 1'b0;
                        r_cnt  <= CNT_LOAD;
                    end
                end
                ST_CALC: begin
                    if (r_cnt == 3'd0) begin
                        r_rsp_p     <= w_prod;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_p      = r_rsp_p;
    assign busy       = (r_state != ST_IDLE);

endmodule
